// File: rtl/mem_stage.sv
// mem_stage: Y86 memory stage.
//
// Takes one execute result per in_valid/in_ready handshake, performs the
// data-memory read or write it needs over a req/ack bus (with alignment and
// timeout checking) and presents the writeback bundle on out_valid/out_ready.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         execute bundle handshake
//   icode_i, valE_i, valA_i     instruction code, ALU result, store data / old %esp
//   dstE_i, dstM_i, cnd_i       destination registers (F = none), condition
//   mem_req/we/addr/wdata       data-memory request, held stable while in REQ
//   mem_ack, mem_rdata          memory response, rdata valid with ack
//   out_valid / out_ready       writeback handshake
//   valE_o, valM_o, dstE_o, dstM_o, stat_o   writeback bundle
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode_i,
    input  logic [31:0] valE_i,
    input  logic [31:0] valA_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    input  logic        cnd_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] valE_o,
    output logic [31:0] valM_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic [2:0]  stat_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 4'd4;

    // Count of the last REQ cycle allowed to pass without an ack.
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    logic [1:0]  state, state_next;
    logic [3:0]  wait_cnt;
    logic        is_mem, is_write, addr_from_a;
    logic [31:0] req_addr;
    logic        misaligned;
    logic        timed_out;

    // Memory-op decode of the incoming icode.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        is_mem      = 1'b0;
        is_write    = 1'b0;
        addr_from_a = 1'b0;
        case (icode_i)
            I_RMMOVL, I_PUSHL, I_CALL: begin
                is_mem   = 1'b1;
                is_write = 1'b1;
            end
            I_MRMOVL: is_mem = 1'b1;
            I_POPL, I_RET: begin
                is_mem      = 1'b1;
                addr_from_a = 1'b1;
            end
            default: ;
        endcase
    end

    // POPL/RET read from the old %esp carried in valA; everything else uses valE.
    assign req_addr   = addr_from_a ? valA_i : valE_i;
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign timed_out  = (wait_cnt == LAST_WAIT);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = (is_mem && !misaligned) ? S_REQ : S_HOLD;
            S_REQ:  if (mem_ack || timed_out) state_next = S_HOLD;
            S_HOLD: if (out_ready) state_next = (stat_o == STAT_AOK) ? S_IDLE : S_STOP;
            default: state_next = S_STOP;
        endcase
    end

    // Handshake flags are registered from the next state so that every output
    // comes straight from a flop.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valE_o    <= '0;
            valM_o    <= '0;
            dstE_o    <= REG_NONE;
            dstM_o    <= REG_NONE;
            stat_o    <= STAT_AOK;
            wait_cnt  <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_HOLD);
            mem_req   <= (state_next == S_REQ);

            case (state)
                S_IDLE: if (in_valid) begin
                    valE_o   <= valE_i;
                    valM_o   <= '0;
                    dstE_o   <= (icode_i == I_CMOVXX && !cnd_i) ? REG_NONE : dstE_i;
                    dstM_o   <= dstM_i;
                    stat_o   <= STAT_AOK;
                    wait_cnt <= '0;
                    if (icode_i == I_HALT) begin
                        stat_o <= STAT_HLT;
                    end else if (icode_i > I_POPL) begin
                        stat_o <= STAT_INS;
                        dstE_o <= REG_NONE;
                        dstM_o <= REG_NONE;
                    end else if (is_mem && misaligned) begin
                        stat_o <= STAT_ADR;
                        dstE_o <= REG_NONE;
                        dstM_o <= REG_NONE;
                    end else if (is_mem) begin
                        mem_we    <= is_write;
                        mem_addr  <= req_addr;
                        mem_wdata <= valA_i;
                    end
                end
                S_REQ: begin
                    // Ack wins over a simultaneous timeout.
                    if (mem_ack) begin
                        if (!mem_we) valM_o <= mem_rdata;
                        mem_we <= 1'b0;
                    end else if (timed_out) begin
                        stat_o <= STAT_ADR;
                        dstE_o <= REG_NONE;
                        dstM_o <= REG_NONE;
                        mem_we <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. Expected writeback bundles are queued
// when an op is driven and compared when the stage presents its output.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode_i = '0;
    logic [31:0] valE_i = '0;
    logic [31:0] valA_i = '0;
    logic [3:0]  dstE_i = 4'hF;
    logic [3:0]  dstM_i = 4'hF;
    logic        cnd_i = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] valE_o, valM_o;
    logic [3:0]  dstE_o, dstM_o;
    logic [2:0]  stat_o;

    typedef struct packed {
        logic [31:0] valE;
        logic [31:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  stat;
    } wb_t;

    wb_t sb[$];
    int  n_pass = 0;
    int  n_total = 0;

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .icode_i(icode_i), .valE_i(valE_i), .valA_i(valA_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .cnd_i(cnd_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .valE_o(valE_o), .valM_o(valM_o), .dstE_o(dstE_o), .dstM_o(dstM_o), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one op for exactly one accepting edge; returns at the negedge after it.
    task automatic issue(input logic [3:0] ic, input logic [31:0] ve, input logic [31:0] va,
                         input logic [3:0] de, input logic [3:0] dm, input logic c);
        @(negedge clk);
        icode_i = ic; valE_i = ve; valA_i = va; dstE_i = de; dstM_i = dm; cnd_i = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wb_t got;
        apply_reset();
        n_total++;
        if ({in_ready, out_valid, mem_req, mem_we} === 4'b1000) n_pass++;
        else $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, mem_req, mem_we});
        n_total++;
        if ({mem_addr, mem_wdata} === 64'h0) n_pass++;
        else $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata});
        got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
        n_total++;
        if (got === {32'h0, 32'h0, 4'hF, 4'hF, 3'd1}) n_pass++;
        else $display("FAIL reset_bundle: got %h want %h", got, {32'h0, 32'h0, 4'hF, 4'hF, 3'd1});
    endtask

    task automatic test_irmovl();
        wb_t got, exp;
        sb.push_back({32'h42, 32'h0, 4'h0, 4'hF, 3'd1});
        issue(4'h3, 32'h42, 32'h0, 4'h0, 4'hF, 1'b1);
        n_total++;
        if ({out_valid, mem_req} === 2'b10) n_pass++;
        else $display("FAIL irmovl_timing: got valid/req %b want 10", {out_valid, mem_req});
        // Stall the consumer; the bundle must stay presented and unchanged.
        repeat (3) @(negedge clk);
        got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
        exp = sb.pop_front();
        n_total++;
        if (out_valid === 1'b1 && got === exp) n_pass++;
        else $display("FAIL irmovl_hold_bundle: got valid=%b %h want valid=1 %h", out_valid, got, exp);
        release_out();
        n_total++;
        if ({in_ready, out_valid} === 2'b10) n_pass++;
        else $display("FAIL irmovl_back_idle: got %b want 10", {in_ready, out_valid});
    endtask

    typedef struct {
        logic [3:0]  ic;
        logic [31:0] ve, va;
        logic [3:0]  de, dm;
        logic        we;
        logic [31:0] addr;
        int          waits;
        logic [31:0] rd;
    } mop_t;

    task automatic test_mem_ops();
        mop_t ops[6];
        wb_t  got, exp;
        ops[0] = '{4'h5, 32'h100, 32'h55,  4'hF, 4'h3, 1'b0, 32'h100, 2, 32'hDEADBEEF};
        ops[1] = '{4'hA, 32'h1FC, 32'h7,   4'h4, 4'hF, 1'b1, 32'h1FC, 0, 32'hBAD0BAD0};
        ops[2] = '{4'hB, 32'h200, 32'h1FC, 4'h4, 4'h0, 1'b0, 32'h1FC, 1, 32'h00001234};
        ops[3] = '{4'h8, 32'h1F8, 32'h40,  4'h4, 4'hF, 1'b1, 32'h1F8, 3, 32'hBAD1BAD1};
        ops[4] = '{4'h9, 32'h1FC, 32'h1F8, 4'h4, 4'hF, 1'b0, 32'h1F8, 0, 32'h00000040};
        ops[5] = '{4'h4, 32'h300, 32'hCAFE, 4'hF, 4'hF, 1'b1, 32'h300, 1, 32'hBAD2BAD2};
        for (int i = 0; i < 6; i++) begin
            sb.push_back({ops[i].ve, ops[i].we ? 32'h0 : ops[i].rd, ops[i].de, ops[i].dm, 3'd1});
            issue(ops[i].ic, ops[i].ve, ops[i].va, ops[i].de, ops[i].dm, 1'b1);
            n_total++;
            if ({mem_req, mem_we, mem_addr, out_valid} === {1'b1, ops[i].we, ops[i].addr, 1'b0}) n_pass++;
            else $display("FAIL memop%0d_request: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                          i, mem_req, mem_we, mem_addr, ops[i].we, ops[i].addr);
            if (ops[i].we) begin
                n_total++;
                if (mem_wdata === ops[i].va) n_pass++;
                else $display("FAIL memop%0d_wdata: got %h want %h", i, mem_wdata, ops[i].va);
            end
            repeat (ops[i].waits) @(negedge clk);
            n_total++;
            if ({mem_req, out_valid, mem_addr} === {2'b10, ops[i].addr}) n_pass++;
            else $display("FAIL memop%0d_wait_stable: got req=%b valid=%b addr=%h", i, mem_req, out_valid, mem_addr);
            mem_ack = 1'b1; mem_rdata = ops[i].rd;
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = '0;
            got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
            exp = sb.pop_front();
            n_total++;
            if (out_valid === 1'b1 && mem_req === 1'b0 && got === exp) n_pass++;
            else $display("FAIL memop%0d_bundle: got valid=%b req=%b %h want %h", i, out_valid, mem_req, got, exp);
            release_out();
        end
    endtask

    task automatic test_cmov();
        wb_t got, exp;
        for (int c = 0; c < 2; c++) begin
            sb.push_back({32'h77, 32'h0, (c == 1) ? 4'h2 : 4'hF, 4'hF, 3'd1});
            issue(4'h2, 32'h77, 32'h77, 4'h2, 4'hF, c[0]);
            got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
            exp = sb.pop_front();
            n_total++;
            if (out_valid === 1'b1 && got === exp) n_pass++;
            else $display("FAIL cmov_cnd%0d: got %h want %h", c, got, exp);
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        wb_t got, exp;
        int  sent = 0, got_n = 0, cyc = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (got_n < 4 && cyc < 30) begin
            if (out_valid) begin
                got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
                exp = sb.pop_front();
                n_total++;
                if (got === exp) n_pass++;
                else $display("FAIL b2b_bundle%0d: got %h want %h", got_n, got, exp);
                got_n++;
            end
            if (in_ready && sent < 4) begin
                icode_i = 4'h6; valE_i = 32'h10 * sent + 32'h1; valA_i = '0;
                dstE_i = sent[3:0]; dstM_i = 4'hF; cnd_i = 1'b1; in_valid = 1'b1;
                sb.push_back({32'h10 * sent + 32'h1, 32'h0, sent[3:0], 4'hF, 3'd1});
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_total++;
        if (got_n == 4 && cyc == 8) n_pass++;
        else $display("FAIL b2b_throughput: got %0d outputs in %0d cycles want 4 in 8", got_n, cyc);
    endtask

    task automatic test_misaligned();
        wb_t got, exp;
        sb.push_back({32'h102, 32'h0, 4'hF, 4'hF, 3'd3});
        issue(4'h4, 32'h102, 32'hAA, 4'hF, 4'hF, 1'b1);
        n_total++;
        if ({mem_req, out_valid} === 2'b01) n_pass++;
        else $display("FAIL misaligned_no_req: got req/valid %b want 01", {mem_req, out_valid});
        got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
        exp = sb.pop_front();
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL misaligned_bundle: got %h want %h", got, exp);
        release_out();
        n_total++;
        if ({in_ready, out_valid, mem_req} === 3'b000) n_pass++;
        else $display("FAIL misaligned_stop: got %b want 000", {in_ready, out_valid, mem_req});
        // New work offered in STOP must be ignored.
        icode_i = 4'h3; valE_i = 32'h9; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if ({in_ready, out_valid, mem_req} === 3'b000) n_pass++;
        else $display("FAIL stop_sticky: got %b want 000", {in_ready, out_valid, mem_req});
        apply_reset();
    endtask

    task automatic test_timeout();
        wb_t got, exp;
        int  req_cycles = 0;
        sb.push_back({32'h200, 32'h0, 4'hF, 4'hF, 3'd3});
        issue(4'h5, 32'h200, 32'h0, 4'hF, 4'h5, 1'b1);
        while (mem_req && req_cycles < 40) begin
            req_cycles++;
            @(negedge clk);
        end
        n_total++;
        if (req_cycles == 15) n_pass++;
        else $display("FAIL timeout_req_cycles: got %0d want 15", req_cycles);
        got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
        exp = sb.pop_front();
        n_total++;
        if (out_valid === 1'b1 && got === exp) n_pass++;
        else $display("FAIL timeout_bundle: got valid=%b %h want %h", out_valid, got, exp);
        release_out();
        n_total++;
        if ({in_ready, out_valid} === 2'b00) n_pass++;
        else $display("FAIL timeout_stop: got %b want 00", {in_ready, out_valid});
        apply_reset();

        // Ack arriving in the last allowed cycle completes normally.
        sb.push_back({32'h204, 32'hA5A5A5A5, 4'hF, 4'h6, 3'd1});
        issue(4'h5, 32'h204, 32'h0, 4'hF, 4'h6, 1'b1);
        repeat (14) @(negedge clk);
        n_total++;
        if ({mem_req, out_valid} === 2'b10) n_pass++;
        else $display("FAIL ack15_still_req: got req/valid %b want 10", {mem_req, out_valid});
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
        exp = sb.pop_front();
        n_total++;
        if (out_valid === 1'b1 && got === exp) n_pass++;
        else $display("FAIL ack15_bundle: got valid=%b %h want %h", out_valid, got, exp);
        release_out();
        n_total++;
        if (in_ready === 1'b1) n_pass++;
        else $display("FAIL ack15_back_idle: got in_ready=%b want 1", in_ready);
    endtask

    task automatic test_halt_ins();
        wb_t got, exp;
        logic [3:0] ic[2]   = '{4'h0, 4'hC};
        logic [3:0] de[2]   = '{4'hF, 4'h1};
        logic [3:0] dm[2]   = '{4'hF, 4'h2};
        logic [2:0] st[2]   = '{3'd2, 3'd4};
        for (int i = 0; i < 2; i++) begin
            sb.push_back({32'h50 + i, 32'h0, 4'hF, 4'hF, st[i]});
            issue(ic[i], 32'h50 + i, 32'h0, de[i], dm[i], 1'b1);
            got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
            exp = sb.pop_front();
            n_total++;
            if (out_valid === 1'b1 && mem_req === 1'b0 && got === exp) n_pass++;
            else $display("FAIL halt_ins%0d_bundle: got valid=%b %h want %h", i, out_valid, got, exp);
            release_out();
            n_total++;
            if ({in_ready, out_valid, mem_req} === 3'b000) n_pass++;
            else $display("FAIL halt_ins%0d_stop: got %b want 000", i, {in_ready, out_valid, mem_req});
            apply_reset();
        end
    endtask

    task automatic test_reset_mid_req();
        wb_t got, exp;
        issue(4'h5, 32'h300, 32'h0, 4'hF, 4'h1, 1'b1);
        @(negedge clk);
        n_total++;
        if (mem_req === 1'b1) n_pass++;
        else $display("FAIL midreq_req_up: got %b want 1", mem_req);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({mem_req, in_ready, out_valid} === 3'b010) n_pass++;
        else $display("FAIL midreq_reset: got req/ready/valid %b want 010", {mem_req, in_ready, out_valid});
        rst = 1'b0;
        sb.push_back({32'h99, 32'h0, 4'h7, 4'hF, 3'd1});
        issue(4'h3, 32'h99, 32'h0, 4'h7, 4'hF, 1'b1);
        got = {valE_o, valM_o, dstE_o, dstM_o, stat_o};
        exp = sb.pop_front();
        n_total++;
        if (out_valid === 1'b1 && got === exp) n_pass++;
        else $display("FAIL midreq_after_bundle: got valid=%b %h want %h", out_valid, got, exp);
        release_out();
    endtask

    initial begin
        test_reset();
        test_irmovl();
        test_mem_ops();
        test_cmov();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_halt_ins();
        test_reset_mid_req();
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drained: got %0d left want 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
